demux1_8_deser: RTL and testbench

- Sequential inverse of the 8:1 bit selector: accepts one lane per beat and steers it into output slot 0..7 using an internal auto-incrementing select counter.
- Presents the assembled 8-slot word with a one-cycle valid strobe.
- Sits at the receive end of links whose transmit end walks an 8:1 selector through sel = 0..7.

---
 rtl/demux8_pkg.sv | 11 +
 rtl/demux8_slot_dec.sv | 14 +
 rtl/demux1_8_deser.sv | 103 ++++++++++
 tb/tb_demux1_8_deser.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/demux8_pkg.sv
// Shared constants and FSM state type for the 1:8 lane deserializer.
// Optional parity state is used only when DEMUX8_PARITY_EN is defined.
package demux8_pkg;
  localparam int NUM_SLOTS = 8;
  localparam int SEL_W     = 3;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PARITY  = 1'b1
  } state_t;
endpackage

// File: rtl/demux8_slot_dec.sv
// Combinational 3-to-8 one-hot slot write-enable decoder.
// Output is all-zero when en is low.
module demux8_slot_dec
  import demux8_pkg::*;
(
  input  logic [SEL_W-1:0]     slot,
  input  logic                 en,
  output logic [NUM_SLOTS-1:0] we
);
  always_comb begin
    we = '0;
    if (en) we = NUM_SLOTS'(1) << slot;
  end
endmodule

// File: rtl/demux1_8_deser.sv
// 1:8 lane deserializer: steers each valid beat into slot sel and strobes
// the assembled word. Define DEMUX8_PARITY_EN for a trailing odd-parity beat.
module demux1_8_deser
  import demux8_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_sync,
  input  logic [DATA_W-1:0]           in_data,
  output logic [SEL_W-1:0]            sel,
  output logic [NUM_SLOTS*DATA_W-1:0] out_data,
  output logic                        out_valid
`ifdef DEMUX8_PARITY_EN
  ,
  output logic                        parity_err
`endif
);
  state_t                        state, state_next;
  logic [DATA_W-1:0]             shadow [NUM_SLOTS];
  logic [SEL_W-1:0]              eff_sel, sel_next;
  logic                          wr_en, complete;
  logic [NUM_SLOTS-1:0]          we;
  logic [NUM_SLOTS*DATA_W-1:0]   word_next;

  demux8_slot_dec u_slot_dec (
    .slot (eff_sel),
    .en   (wr_en),
    .we   (we)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_COLLECT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    eff_sel    = sel;
    sel_next   = sel;
    wr_en      = 1'b0;
    complete   = 1'b0;
    if (in_valid) begin
      if (in_sync) begin
        // Sync always restarts at slot 0, even over a pending parity beat.
        eff_sel    = '0;
        wr_en      = 1'b1;
        sel_next   = SEL_W'(1);
        state_next = ST_COLLECT;
      end else if (state == ST_COLLECT) begin
        wr_en    = 1'b1;
        sel_next = sel + SEL_W'(1);
        if (sel == SEL_W'(NUM_SLOTS - 1)) begin
`ifdef DEMUX8_PARITY_EN
          state_next = ST_PARITY;
`else
          complete = 1'b1;
`endif
        end
      end
`ifdef DEMUX8_PARITY_EN
      else begin
        complete   = 1'b1;
        state_next = ST_COLLECT;
      end
`endif
    end
  end

  always_comb begin
    word_next = '0;
    for (int k = 0; k < NUM_SLOTS; k++)
      word_next[k*DATA_W +: DATA_W] = shadow[k];
`ifndef DEMUX8_PARITY_EN
    // Slot 7 bypasses the shadow so the word is out one cycle after its beat.
    word_next[(NUM_SLOTS-1)*DATA_W +: DATA_W] = in_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) shadow[k] <= '0;
    end else begin
      sel       <= sel_next;
      out_valid <= complete;
      if (complete) out_data <= word_next;
      for (int k = 0; k < NUM_SLOTS; k++)
        if (we[k]) shadow[k] <= in_data;
    end
  end

`ifdef DEMUX8_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)           parity_err <= 1'b0;
    else if (complete) parity_err <= ~(^word_next ^ in_data[0]);
  end
`endif
endmodule

// File: tb/tb_demux1_8_deser.sv
// Directed self-checking bench for demux1_8_deser (DATA_W=1 and DATA_W=4).
// The parity scenario is compiled only with DEMUX8_PARITY_EN.
module tb_demux1_8_deser;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v1, s1;
  logic [0:0]  d1;
  logic [2:0]  sel1;
  logic [7:0]  od1;
  logic        ov1;
  logic        v4, s4;
  logic [3:0]  d4;
  logic [2:0]  sel4;
  logic [31:0] od4;
  logic        ov4;
`ifdef DEMUX8_PARITY_EN
  logic        pe1, pe4;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int strobes1 = 0;

  always @(posedge clk) cyc++;

  demux1_8_deser #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_sync(s1), .in_data(d1),
    .sel(sel1), .out_data(od1), .out_valid(ov1)
`ifdef DEMUX8_PARITY_EN
    , .parity_err(pe1)
`endif
  );

  demux1_8_deser #(.DATA_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_sync(s4), .in_data(d4),
    .sel(sel4), .out_data(od4), .out_valid(ov4)
`ifdef DEMUX8_PARITY_EN
    , .parity_err(pe4)
`endif
  );

  task automatic step1(input logic v, input logic s, input logic d);
    @(negedge clk);
    v1 = v; s1 = s; d1 = d;
    @(posedge clk);
    #1;
    if (ov1) strobes1++;
  endtask

  task automatic step4(input logic v, input logic s, input logic [3:0] d);
    @(negedge clk);
    v4 = v; s4 = s; d4 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; v1 = 1'b1; s1 = 1'b0; d1 = 1'b1; v4 = 1'b1; s4 = 1'b0; d4 = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    total++; if (sel1 !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", sel1); end
    total++; if (od1 !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", od1); end
    total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ov1); end
    total++; if (od4 !== 32'h0) begin bad++; $display("FAIL reset_data4 got=%h want=0", od4); end
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0; d1 = 1'b0; v4 = 1'b0; d4 = 4'h0;
    @(posedge clk);
    #1;
    total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b want=0", ov1); end
  endtask

  task automatic test_single_frame;
    logic [7:0] bits;
    bits = 8'h4D;
    strobes1 = 0;
    for (int i = 0; i < 8; i++) begin
      step1(1'b1, i == 0, bits[i]);
      total++;
      if (sel1 !== 3'((i + 1) % 8)) begin
        bad++; $display("FAIL frame_sel beat=%0d got=%0d want=%0d", i, sel1, (i + 1) % 8);
      end
    end
    total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL frame_valid got=%b want=1", ov1); end
    total++; if (od1 !== 8'h4D) begin bad++; $display("FAIL frame_data got=%h want=4d", od1); end
    step1(1'b0, 1'b0, 1'b0);
    total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL frame_strobe_len got=%b want=0", ov1); end
    total++; if (od1 !== 8'h4D) begin bad++; $display("FAIL frame_hold got=%h want=4d", od1); end
    total++; if (strobes1 != 1) begin bad++; $display("FAIL frame_strobes got=%0d want=1", strobes1); end
  endtask

  task automatic test_gaps;
    logic [7:0] bits;
    bits = 8'h4D;
    strobes1 = 0;
    for (int i = 0; i < 8; i++) begin
      step1(1'b1, i == 0, bits[i]);
      // Idle beats, one carrying a stray sync that must be ignored.
      step1(1'b0, i == 3, 1'b1);
      step1(1'b0, 1'b0, 1'b0);
      total++;
      if (sel1 !== 3'((i + 1) % 8)) begin
        bad++; $display("FAIL gap_sel beat=%0d got=%0d want=%0d", i, sel1, (i + 1) % 8);
      end
    end
    total++; if (od1 !== 8'h4D) begin bad++; $display("FAIL gap_data got=%h want=4d", od1); end
    total++; if (strobes1 != 1) begin bad++; $display("FAIL gap_strobes got=%0d want=1", strobes1); end
  endtask

  task automatic test_resync;
    strobes1 = 0;
    for (int i = 0; i < 5; i++) step1(1'b1, i == 0, 1'b0);
    total++; if (sel1 !== 3'd5) begin bad++; $display("FAIL resync_partial_sel got=%0d want=5", sel1); end
    for (int i = 0; i < 8; i++) begin
      step1(1'b1, i == 0, 1'b1);
      if (i == 0) begin
        total++; if (sel1 !== 3'd1) begin bad++; $display("FAIL resync_sel got=%0d want=1", sel1); end
      end
    end
    total++; if (od1 !== 8'hFF) begin bad++; $display("FAIL resync_data got=%h want=ff", od1); end
    step1(1'b0, 1'b0, 1'b0);
    total++; if (strobes1 != 1) begin bad++; $display("FAIL resync_strobes got=%0d want=1", strobes1); end
  endtask

  task automatic test_back_to_back;
    int t1, t2, n;
    t1 = -1; t2 = -1; n = 0;
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, i == 0, 4'(i));
      if (ov4) begin
        n++;
        if (t1 < 0) begin
          t1 = cyc;
          total++;
          if (od4 !== 32'h76543210) begin bad++; $display("FAIL b2b_word0 got=%h want=76543210", od4); end
        end else begin
          t2 = cyc;
          total++;
          if (od4 !== 32'hFEDCBA98) begin bad++; $display("FAIL b2b_word1 got=%h want=fedcba98", od4); end
        end
      end
    end
    step4(1'b0, 1'b0, 4'h0);
    total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL b2b_strobe_len got=%b want=0", ov4); end
    total++; if (n != 2) begin bad++; $display("FAIL b2b_strobes got=%0d want=2", n); end
    total++; if (t2 - t1 != 8) begin bad++; $display("FAIL b2b_spacing got=%0d want=8", t2 - t1); end
    total++; if (sel4 !== 3'd0) begin bad++; $display("FAIL b2b_sel_wrap got=%0d want=0", sel4); end
  endtask

`ifdef DEMUX8_PARITY_EN
  task automatic test_parity;
    logic [7:0] bits;
    bits = 8'h4D;
    for (int p = 1; p >= 0; p--) begin
      for (int i = 0; i < 8; i++) step1(1'b1, i == 0, bits[i]);
      total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL par_early got=%b want=0", ov1); end
      total++; if (sel1 !== 3'd0) begin bad++; $display("FAIL par_sel got=%0d want=0", sel1); end
      step1(1'b1, 1'b0, 1'(p));
      total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL par_valid got=%b want=1", ov1); end
      total++; if (od1 !== 8'h4D) begin bad++; $display("FAIL par_data got=%h want=4d", od1); end
      total++;
      if (pe1 !== 1'(1 - p)) begin bad++; $display("FAIL par_err p=%0d got=%b want=%0d", p, pe1, 1 - p); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; v1 = 1'b0; s1 = 1'b0; d1 = 1'b0; v4 = 1'b0; s4 = 1'b0; d4 = 4'h0;
    test_reset;
`ifdef DEMUX8_PARITY_EN
    test_parity;
`else
    test_single_frame;
    test_gaps;
    test_resync;
    test_back_to_back;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
